data_memory_ctrl: RTL and testbench

Parametrised, byte-addressed, little-endian data memory for the pipeline's MEM stage, replacing the fixed 32-byte word-only data memory. It adds byte/half/word access sizes with sign or zero extension, a request/response handshake with configurable read latency, and a hardware clear sequence after reset. It sits between the EX/MEM pipeline register and the writeback mux; the pipeline stalls on `ready_o` low.

---
 rtl/data_memory_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressed, little-endian data memory for the MEM stage.
// Byte/half/word loads and stores with sign/zero extension, a READ_LAT-deep
// response pipeline and a hardware clear sequence (INIT) after reset.
// Build option: define DATA_MEMORY_ALIGN_CHECK_EN to reject misaligned half/word
// accesses; without it, misaligned accesses complete byte-wise with address wrap.
`timescale 1ns/1ps
module data_memory_ctrl #(
  parameter int DEPTH_BYTES = 1024,
  parameter int READ_LAT    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] data_o,
  output logic        err_o,
  output logic        init_done_o
);
  localparam int AW   = $clog2(DEPTH_BYTES);
  localparam int RW   = AW - 2;
  localparam int ROWS = DEPTH_BYTES / 4;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  genvar gi;

  logic [0:0]    state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          init_wr;
  logic          accept;
  logic [AW-1:0] byte_addr;
  logic [2:0]    nbytes;
  logic          req_err;
  logic          unused_addr;

  // response stage 1: metadata captured alongside the RAM read
  logic       s1_valid_q;
  logic       s1_err_q;
  logic       s1_rd_q;
  logic [1:0] s1_off_q;
  logic [1:0] s1_size_q;
  logic       s1_uns_q;

  logic [3:0][7:0] rd_byte;
  logic [31:0]     raw;
  logic [31:0]     ext;
  logic [1:0]      rd_lane;

  logic [READ_LAT-1:0]       pv;
  logic [READ_LAT-1:0]       pe;
  logic [READ_LAT-1:0][31:0] pd;

  assign ready_o     = (state_q == ST_RUN);
  assign init_done_o = (state_q == ST_RUN);
  assign accept      = req_i && ready_o;
  assign init_wr     = (state_q == ST_INIT) && rst_i;
  assign byte_addr   = addr_i[AW-1:0];
  assign unused_addr = ^addr_i[31:AW];

  // INIT walks one word per cycle, then hands over to RUN for good
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == RW'(ROWS - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  // state and clear-counter registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // request decode: access width and rejection
  always_comb begin
    nbytes  = 3'd4;
    req_err = (size_i == 2'b11);
    case (size_i)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
    if ((size_i == 2'b01) && byte_addr[0]) begin
      req_err = 1'b1;
    end
    if ((size_i == 2'b10) && (byte_addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end
`endif
  end

  // Four byte-wide banks, bank = address[1:0]. Access byte k lands in bank
  // (addr+k) mod 4, so each bank works out which k it serves and its own row,
  // which makes misaligned and wrapping accesses fall out naturally.
  for (gi = 0; gi < 4; gi++) begin : g_bank
    logic [7:0]    ram [ROWS];
    logic [7:0]    rd_q;
    logic [1:0]    lane;
    logic [AW-1:0] lane_addr;
    logic          wr_en;
    logic [RW-1:0] wr_row;
    logic [7:0]    wr_byte;
    logic [7:0]    st_byte;

    assign lane      = 2'(gi) - byte_addr[1:0];
    assign lane_addr = byte_addr + AW'(lane);

    // pick the store byte this bank receives
    always_comb begin
      st_byte = data_i[7:0];
      case (lane)
        2'd0:    st_byte = data_i[7:0];
        2'd1:    st_byte = data_i[15:8];
        2'd2:    st_byte = data_i[23:16];
        default: st_byte = data_i[31:24];
      endcase
    end

    assign wr_en   = init_wr || (accept && we_i && !req_err && ({1'b0, lane} < nbytes));
    assign wr_row  = init_wr ? cnt_q : lane_addr[AW-1:2];
    assign wr_byte = init_wr ? 8'h00 : st_byte;

    // single write port with registered read (read-before-write)
    always_ff @(posedge clk_i) begin
      if (wr_en) begin
        ram[wr_row] <= wr_byte;
      end
      rd_q <= ram[lane_addr[AW-1:2]];
    end

    assign rd_byte[gi] = rd_q;
  end

  // capture request attributes at the acceptance edge
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_rd_q    <= 1'b0;
      s1_off_q   <= 2'b00;
      s1_size_q  <= 2'b00;
      s1_uns_q   <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      s1_err_q   <= accept && req_err;
      s1_rd_q    <= accept && !we_i && !req_err;
      s1_off_q   <= byte_addr[1:0];
      s1_size_q  <= size_i;
      s1_uns_q   <= unsigned_i;
    end
  end

  // reassemble little-endian bytes from the banks and extend
  always_comb begin
    raw     = '0;
    rd_lane = 2'b00;
    for (int k = 0; k < 4; k++) begin
      rd_lane         = s1_off_q + 2'(k);
      raw[8*k +: 8]   = rd_byte[rd_lane];
    end
    case (s1_size_q)
      2'b00:   ext = {{24{~s1_uns_q & raw[7]}}, raw[7:0]};
      2'b01:   ext = {{16{~s1_uns_q & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  assign pv[0] = s1_valid_q;
  assign pe[0] = s1_err_q;
  assign pd[0] = s1_rd_q ? ext : 32'h0;

  // remaining READ_LAT-1 response stages
  for (gi = 1; gi < READ_LAT; gi++) begin : g_pipe
    logic        v_q;
    logic        e_q;
    logic [31:0] d_q;

    // shift the response one stage; reset drops anything in flight
    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        v_q <= 1'b0;
        e_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= pv[gi-1];
        e_q <= pe[gi-1];
        d_q <= pd[gi-1];
      end
    end

    assign pv[gi] = v_q;
    assign pe[gi] = e_q;
    assign pd[gi] = d_q;
  end

  assign rvalid_o = pv[READ_LAT-1];
  assign err_o    = pe[READ_LAT-1];
  assign data_o   = pd[READ_LAT-1];

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: three instances (READ_LAT 1, 2, 3) share one
// stimulus stream; a byte-array model predicts every response.
`timescale 1ns/1ps
module tb_data_memory_ctrl;
  localparam int DEPTH = 64;
  localparam int ND    = 3;
  localparam int NE    = 4096;
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic [ND-1:0] ready_w, rvalid_w, err_w, init_w;
  logic [31:0]   data_w [ND];

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  logic [7:0]  mdl [DEPTH];
  logic        exp_v [NE];
  logic        exp_e [NE];
  logic [31:0] exp_d [NE];
  logic        got_v [ND][NE];
  logic        got_e [ND][NE];
  logic [31:0] got_d [ND][NE];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .READ_LAT(gi + 1)) u_dut (
      .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .size_i(size),
      .unsigned_i(uns), .addr_i(addr), .data_i(wdata), .ready_o(ready_w[gi]),
      .rvalid_o(rvalid_w[gi]), .data_o(data_w[gi]), .err_o(err_w[gi]),
      .init_done_o(init_w[gi]));
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  // file each DUT's output under the edge whose request it should answer
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (edge_n - d >= 0) begin
        got_v[d][(edge_n - d) % NE] = rvalid_w[d];
        got_e[d][(edge_n - d) % NE] = err_w[d];
        got_d[d][(edge_n - d) % NE] = data_w[d];
      end
    end
  end

  // drive one request for one cycle and record the model's expected response
  task automatic issue(input bit w, input bit [1:0] sz, input bit u,
                       input bit [31:0] a, input bit [31:0] dat, output int s);
    int nb, base;
    bit e;
    bit [31:0] v;
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = dat;
    s = edge_n + 1;
    base = int'(a % DEPTH);
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e = (sz == 2'd3);
    if (ALIGN && ((sz == 2'd1 && base % 2 != 0) || (sz == 2'd2 && base % 4 != 0))) e = 1'b1;
    v = 32'h0;
    if (!e) begin
      for (int k = 0; k < nb; k++) begin
        if (w) mdl[(base + k) % DEPTH] = dat[8*k +: 8];
        else   v = v | (32'(mdl[(base + k) % DEPTH]) << (8 * k));
      end
      if (!w && !u && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
    end
    exp_v[s % NE] = 1'b1;
    exp_e[s % NE] = e;
    exp_d[s % NE] = v;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    int cnt, s0, s1;
    rst_n = 1'b0; req = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if (ready_w[d] !== 1'b0 || rvalid_w[d] !== 1'b0 || err_w[d] !== 1'b0 ||
          data_w[d] !== 32'h0 || init_w[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state lat%0d: ready=%b rvalid=%b err=%b data=%h init_done=%b, want all 0",
                 d + 1, ready_w[d], rvalid_w[d], err_w[d], data_w[d], init_w[d]);
      end
    end
    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
    rst_n = 1'b1;
    // stores attempted during INIT must be ignored
    req = 1'b1; we = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h20; wdata = 32'hDEADBEEF;
    s0 = edge_n + 1;
    cnt = 0;
    while (ready_w[0] !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    req = 1'b0;
    s1 = edge_n;
    vectors++;
    if (cnt != DEPTH / 4) begin
      miscompares++;
      $display("FAIL init_cycles: ready low %0d cycles, want %0d", cnt, DEPTH / 4);
    end
    vectors++;
    if (ready_w !== 3'b111 || init_w !== 3'b111) begin
      miscompares++;
      $display("FAIL init_done: ready=%b init_done=%b, want 111/111", ready_w, init_w);
    end
    repeat (3) @(negedge clk);
    for (int s = s0; s <= s1; s++) begin
      for (int d = 0; d < ND; d++) begin
        vectors++;
        if (got_v[d][s % NE] !== 1'b0) begin
          miscompares++;
          $display("FAIL init_ignore lat%0d edge %0d: rvalid=%b, want 0", d + 1, s, got_v[d][s % NE]);
        end
      end
    end
  endtask

  task automatic test_directed();
    int sl [8];
    bit [31:0] want [8];
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, sl[0]);        want[0] = 32'h00000000;
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h8081F27F, sl[1]); want[1] = 32'h00000000;
    issue(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, sl[2]);        want[2] = 32'h0000007F;
    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, sl[3]);        want[3] = 32'hFFFFFFF2;
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, sl[4]);        want[4] = 32'h00008081;
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, sl[5]);        want[5] = 32'hFFFF8081;
    issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AA, sl[6]); want[6] = 32'h00000000;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, sl[7]);        want[7] = 32'hAA81F27F;
    idle(4);
    for (int i = 0; i < 8; i++) begin
      for (int d = 0; d < ND; d++) begin
        vectors++;
        if (got_v[d][sl[i] % NE] !== 1'b1 || got_e[d][sl[i] % NE] !== 1'b0 ||
            got_d[d][sl[i] % NE] !== want[i]) begin
          miscompares++;
          $display("FAIL directed#%0d lat%0d: rvalid=%b err=%b data=%h, want 1/0/%h",
                   i, d + 1, got_v[d][sl[i] % NE], got_e[d][sl[i] % NE], got_d[d][sl[i] % NE], want[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int s, s0, s1;
    s0 = edge_n + 1;
    for (int i = 0; i < 4; i++) issue(1'b0, 2'd0, 1'b1, 32'h10 + i, 32'h0, s);
    s1 = s;
    idle(4);
    for (int t = s0 - 1; t <= s1 + 1; t++) begin
      for (int d = 0; d < ND; d++) begin
        vectors++;
        if (got_v[d][t % NE] !== exp_v[t % NE] ||
            (exp_v[t % NE] && (got_e[d][t % NE] !== exp_e[t % NE] || got_d[d][t % NE] !== exp_d[t % NE]))) begin
          miscompares++;
          $display("FAIL b2b lat%0d edge %0d: rvalid=%b err=%b data=%h, want %b/%b/%h", d + 1, t,
                   got_v[d][t % NE], got_e[d][t % NE], got_d[d][t % NE], exp_v[t % NE], exp_e[t % NE], exp_d[t % NE]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int sl [8];
    bit we_e [8];
    bit [31:0] want [8];
    issue(1'b1, 2'd2, 1'b0, 32'h3E, 32'h11223344, sl[0]); we_e[0] = ALIGN; want[0] = 32'h0;
    issue(1'b0, 2'd0, 1'b1, 32'h3E, 32'h0, sl[1]); we_e[1] = 1'b0; want[1] = ALIGN ? 32'h0 : 32'h44;
    issue(1'b0, 2'd0, 1'b1, 32'h3F, 32'h0, sl[2]); we_e[2] = 1'b0; want[2] = ALIGN ? 32'h0 : 32'h33;
    issue(1'b0, 2'd0, 1'b1, 32'h00, 32'h0, sl[3]); we_e[3] = 1'b0; want[3] = ALIGN ? 32'h0 : 32'h22;
    issue(1'b0, 2'd0, 1'b1, 32'h01, 32'h0, sl[4]); we_e[4] = 1'b0; want[4] = ALIGN ? 32'h0 : 32'h11;
    issue(1'b0, 2'd3, 1'b0, 32'h04, 32'h0, sl[5]); we_e[5] = 1'b1; want[5] = 32'h0;
    issue(1'b1, 2'd3, 1'b0, 32'h08, 32'hFFFFFFFF, sl[6]); we_e[6] = 1'b1; want[6] = 32'h0;
    issue(1'b0, 2'd2, 1'b1, 32'h08, 32'h0, sl[7]); we_e[7] = 1'b0; want[7] = 32'h0;
    idle(4);
    for (int i = 0; i < 8; i++) begin
      for (int d = 0; d < ND; d++) begin
        vectors++;
        if (got_v[d][sl[i] % NE] !== 1'b1 || got_e[d][sl[i] % NE] !== we_e[i] ||
            got_d[d][sl[i] % NE] !== want[i]) begin
          miscompares++;
          $display("FAIL wrap#%0d lat%0d: rvalid=%b err=%b data=%h, want 1/%b/%h", i, d + 1,
                   got_v[d][sl[i] % NE], got_e[d][sl[i] % NE], got_d[d][sl[i] % NE], we_e[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int s, s0, s1, r;
    bit [1:0] sz;
    s0 = edge_n + 1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom, $urandom, s);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    s1 = edge_n;
    idle(4);
    for (int t = s0; t <= s1; t++) begin
      for (int d = 0; d < ND; d++) begin
        vectors++;
        if (got_v[d][t % NE] !== exp_v[t % NE] ||
            (exp_v[t % NE] && (got_e[d][t % NE] !== exp_e[t % NE] || got_d[d][t % NE] !== exp_d[t % NE]))) begin
          miscompares++;
          $display("FAIL random lat%0d edge %0d: rvalid=%b err=%b data=%h, want %b/%b/%h", d + 1, t,
                   got_v[d][t % NE], got_e[d][t % NE], got_d[d][t % NE], exp_v[t % NE], exp_e[t % NE], exp_d[t % NE]);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    int sa, sb, r, sc, sd;
    bit want;
    issue(1'b1, 2'd2, 1'b0, 32'h18, 32'hCAFEF00D, sa);
    idle(1);
    issue(1'b0, 2'd2, 1'b0, 32'h18, 32'h0, sa);
    issue(1'b0, 2'd0, 1'b1, 32'h19, 32'h0, sb);
    r = edge_n + 1;
    test_reset();
    // a response survives only if it left before the reset edge
    for (int d = 0; d < ND; d++) begin
      for (int j = 0; j < 2; j++) begin
        want = ((sa + j + d) < r);
        vectors++;
        if (got_v[d][(sa + j) % NE] !== want) begin
          miscompares++;
          $display("FAIL inflight lat%0d load%0d: rvalid=%b, want %b", d + 1, j, got_v[d][(sa + j) % NE], want);
        end
      end
    end
    issue(1'b0, 2'd2, 1'b0, 32'h18, 32'h0, sc);
    issue(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, sd);
    idle(4);
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if (got_v[d][sc % NE] !== 1'b1 || got_d[d][sc % NE] !== 32'h0 ||
          got_v[d][sd % NE] !== 1'b1 || got_d[d][sd % NE] !== 32'h0) begin
        miscompares++;
        $display("FAIL post_reset_clear lat%0d: rvalid=%b/%b data=%h/%h, want 1/1 00000000/00000000", d + 1,
                 got_v[d][sc % NE], got_v[d][sd % NE], got_d[d][sc % NE], got_d[d][sd % NE]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NE; i++) begin
      exp_v[i] = 1'b0; exp_e[i] = 1'b0; exp_d[i] = 32'h0;
    end
    test_reset();
    test_directed();
    test_back_to_back();
    test_wrap();
    test_random();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
